// File: rtl/bootprom_reader.sv
// bootprom_reader: read controller for a pair of 27256 boot EPROMs (high/low byte).
// Takes a word-read request, drives the shared address, CE_n and OE_n pins, waits
// ACCESS_CYCLES clocks with both enables low, then samples the two byte buses and
// returns one 16-bit word with a single-cycle ack.
// Optional feature: define BOOTPROM_CACHE_EN to add a one-entry read cache in front of the PROMs.
module bootprom_reader #(
    parameter int unsigned ACCESS_CYCLES   = 4,
    parameter int unsigned RECOVERY_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [14:0] addr,
    output logic [15:0] data,
    output logic        ack,
    output logic        busy,
    output logic [14:0] prom_a,
    output logic        prom_ce_n,
    output logic        prom_oe_n,
    input  logic [7:0]  prom_d_h,
    input  logic [7:0]  prom_d_l
);

    // The counter only ever holds (cycles - 1) of either phase.
    localparam int unsigned CNT_MAX = (ACCESS_CYCLES > RECOVERY_CYCLES) ? ACCESS_CYCLES
                                                                        : RECOVERY_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;

    logic [14:0]        prom_a_q, prom_a_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic [15:0]        data_q, data_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;

    // Request accepted from IDLE and served out of the cache instead of the PROMs.
    logic               cache_hit;
    // Last ACCESS cycle: the PROM data is sampled on this edge.
    logic               access_done;

    assign access_done = (state_q == ACCESS) && (cnt_q == '0);

`ifdef BOOTPROM_CACHE_EN
    logic               c_valid_q, c_valid_d;
    logic [14:0]        c_tag_q, c_tag_d;
    logic [15:0]        c_word_q, c_word_d;
    logic               hit_ack_q, hit_ack_d;

    assign cache_hit = (state_q == IDLE) && req && armed_q && c_valid_q && (addr == c_tag_q);

    // Cache fill on every completed PROM access; a hit schedules its ack for the next edge.
    always_comb begin
        c_valid_d = c_valid_q;
        c_tag_d   = c_tag_q;
        c_word_d  = c_word_q;
        hit_ack_d = cache_hit;
        if (access_done) begin
            c_valid_d = 1'b1;
            c_tag_d   = prom_a_q;
            c_word_d  = {prom_d_h, prom_d_l};
        end
    end

    // Cache registers; reset invalidates the entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            c_valid_q <= 1'b0;
            c_tag_q   <= '0;
            c_word_q  <= '0;
            hit_ack_q <= 1'b0;
        end else begin
            c_valid_q <= c_valid_d;
            c_tag_q   <= c_tag_d;
            c_word_q  <= c_word_d;
            hit_ack_q <= hit_ack_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // State register plus all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            prom_a_q <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            data_q   <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            prom_a_q <= prom_a_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    // Next state, phase counter and one-access-per-request arming.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (!req) begin
            armed_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (req && armed_q) begin
                    armed_d = 1'b0;
                    if (!cache_hit) begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = ACC_LOAD;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // Output values for the next cycle; enables decode the next state so OE_n low implies CE_n low.
    always_comb begin
        prom_a_d = prom_a_q;
        data_d   = data_q;
        ack_d    = 1'b0;
        ce_n_d   = !((state_d == SETUP) || (state_d == ACCESS));
        oe_n_d   = (state_d != ACCESS);
        busy_d   = (state_d != IDLE);
        if ((state_q == IDLE) && (state_d == SETUP)) begin
            prom_a_d = addr;
        end
        if (access_done) begin
            data_d = {prom_d_h, prom_d_l};
            ack_d  = 1'b1;
        end
`ifdef BOOTPROM_CACHE_EN
        if (hit_ack_q) begin
            data_d = c_word_q;
            ack_d  = 1'b1;
        end
`endif
    end

    assign data      = data_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign prom_a    = prom_a_q;
    assign prom_ce_n = ce_n_q;
    assign prom_oe_n = oe_n_q;

endmodule

// File: tb/tb_bootprom_reader.sv
// Directed + randomized bench for bootprom_reader with a word-level PROM/cache model.
module tb_bootprom_reader;

    localparam int ACC = 4;
    localparam int REC = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [14:0] addr_i;
    logic [15:0] data;
    logic        ack;
    logic        busy;
    logic [14:0] prom_a;
    logic        prom_ce_n;
    logic        prom_oe_n;
    logic [7:0]  prom_d_h;
    logic [7:0]  prom_d_l;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int glitch = 0;

    // Reference PROM contents and cache model
    logic [15:0] mem [0:32767];
    bit          c_valid = 1'b0;
    logic [14:0] c_tag   = '0;
    logic [15:0] c_word  = '0;

    bootprom_reader #(.ACCESS_CYCLES(ACC), .RECOVERY_CYCLES(REC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .addr      (addr_i),
        .data      (data),
        .ack       (ack),
        .busy      (busy),
        .prom_a    (prom_a),
        .prom_ce_n (prom_ce_n),
        .prom_oe_n (prom_oe_n),
        .prom_d_h  (prom_d_h),
        .prom_d_l  (prom_d_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PROM pins: valid data only while both enables are low, filler otherwise.
    assign prom_d_h = (!prom_ce_n && !prom_oe_n) ? mem[prom_a][15:8] : 8'h5A;
    assign prom_d_l = (!prom_ce_n && !prom_oe_n) ? mem[prom_a][7:0]  : 8'hA5;

    always @(negedge clk) begin
        if (!prom_oe_n && prom_ce_n) glitch <= glitch + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read transaction; the model decides hit/miss, data, latency and PROM activity.
    task automatic do_read(input logic [14:0] a, input int hold, output int t_ack);
        logic [15:0] exp_d;
        bit          hit;
        int          n;
        int          ce_cnt;
        int          acks;
        logic        busy_at1;
        hit = 1'b0;
`ifdef BOOTPROM_CACHE_EN
        hit = c_valid && (c_tag == a);
`endif
        exp_d = hit ? c_word : mem[a];
        @(negedge clk);
        req    = 1'b1;
        addr_i = a;
        n = 0;
        ce_cnt = 0;
        busy_at1 = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!prom_ce_n) ce_cnt++;
            if (n == 1) busy_at1 = busy;
            if (n == 2) addr_i = 15'($urandom);
        end while (!ack && n < 40);
        t_ack = cyc;
        check("ack_latency", 32'(n - 1), hit ? 32'd1 : 32'(ACC + 1));
        check("read_data", 32'(data), 32'(exp_d));
        check("ce_low_cycles", 32'(ce_cnt), hit ? 32'd0 : 32'(ACC + 1));
        check("busy_during", 32'(busy_at1), hit ? 32'd0 : 32'd1);
        if (!hit) begin
            check("prom_a", 32'(prom_a), 32'(a));
            c_valid = 1'b1;
            c_tag   = a;
            c_word  = mem[a];
        end
        acks = 0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        if (hold > 0) begin
            check("no_reaccept", 32'(acks), 32'd0);
            check("idle_while_held", 32'(busy), 32'd0);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int acks;
        logic [14:0] a;
        logic [14:0] last_a;

        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[15'h0123] = 16'hBEEF;
        mem[15'h7FFF] = 16'hC3A5;
        mem[15'h0000] = 16'h1234;

        // Reset held with req high: everything at reset values
        reset_n = 1'b0;
        req     = 1'b1;
        addr_i  = 15'h1234;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_n", 32'(prom_ce_n), 32'd1);
        check("rst_oe_n", 32'(prom_oe_n), 32'd1);
        check("rst_prom_a", 32'(prom_a), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        req     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);

        // Single read of 0x0123
        do_read(15'h0123, 0, t1);

        // Request held long after ack: one access only, then a fresh request works
        do_read(15'h0456, 20, t1);
        do_read(15'h0789, 0, t1);

        // Back-to-back address extremes
        do_read(15'h0000, 0, t1);
        do_read(15'h7FFF, 0, t2);
        check("b2b_spacing", 32'(t2 - t1), 32'(ACC + REC + 2));

        // Reset in the middle of ACCESS
        @(negedge clk);
        req    = 1'b1;
        addr_i = 15'h0321;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_oe_n", 32'(prom_oe_n), 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ce_n", 32'(prom_ce_n), 32'd1);
        check("abort_oe_n", 32'(prom_oe_n), 32'd1);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_data", 32'(data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        req     = 1'b0;
        c_valid = 1'b0;
        acks = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        do_read(15'h0123, 0, t1);

`ifdef BOOTPROM_CACHE_EN
        // Repeat read served from the cache, neighbour goes to the PROMs
        do_read(15'h0040, 0, t1);
        do_read(15'h0040, 0, t1);
        do_read(15'h0041, 0, t1);
`endif

        // Randomized reads, some repeating the previous address
        last_a = 15'h0123;
        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 3) == 0) ? last_a : 15'($urandom);
            do_read(a, $urandom_range(0, 3), t1);
            last_a = a;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        check("oe_without_ce", 32'(glitch), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
